// File: rtl/gpo_uart_pkg.sv
// Shared FSM type and frame constants for the GPO-strobed UART transmitter.
package gpo_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned FRAME_BITS = 32'd10;
  localparam int unsigned TOG_BIT    = 32'd7;
  localparam int unsigned DATA_W     = 32'd7;

endpackage

// File: rtl/gpo_uart_fifo.sv
// Synchronous FIFO used as the character queue when GPO_UART_TX_FIFO_EN is defined.
// DEPTH must be a power of two >= 2; the caller never pushes when full without a pop.
module gpo_uart_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/gpo_uart_tx.sv
// Toggle-strobed 8N1 UART transmitter fed from the fsoc GPO word.
// GPO_UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue; otherwise a single holding register.
module gpo_uart_tx
  import gpo_uart_pkg::*;
#(
  parameter int unsigned CLKDIV     = 87,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic [7:0] gpo_i,
  output logic       tx_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       ovf_o
);

  localparam int unsigned BAUD_W = $clog2(CLKDIV);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              tog_q, tog_d;
  logic              ovf_q, ovf_d;

  logic              wr_s, accept_s, pop_s;
  logic [DATA_W:0]   push_data_s;
  logic [DATA_W:0]   q_dout_s;
  logic              q_full_s, q_empty_s;
  logic [CNT_W-1:0]  q_count_s;

  assign push_data_s = {1'b0, gpo_i[DATA_W-1:0]};

  // A pop in the same cycle frees a slot, so a write to a full queue is still taken.
  always_comb begin
    tog_d    = gpo_i[TOG_BIT];
    wr_s     = (gpo_i[TOG_BIT] != tog_q);
    accept_s = wr_s && (!q_full_s || pop_s);
    ovf_d    = ovf_q | (wr_s & ~accept_s);
  end

`ifdef GPO_UART_TX_FIFO_EN
  gpo_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .din_i   (push_data_s),
    .dout_o  (q_dout_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s),
    .count_o (q_count_s)
  );
`else
  logic            hold_valid_q, hold_valid_d;
  logic [DATA_W:0] hold_q, hold_d;

  // Single-entry holding register in front of the shifter.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept_s) begin
      hold_d       = push_data_s;
      hold_valid_d = 1'b1;
    end else if (pop_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      hold_q       <= {(DATA_W + 1){1'b0}};
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign q_dout_s  = hold_q;
  assign q_full_s  = hold_valid_q;
  assign q_empty_s = !hold_valid_q;
  assign q_count_s = {{(CNT_W - 1){1'b0}}, hold_valid_q};
`endif

  // Frame sequencer; tx_d follows the next state so tx_o changes with it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = {BAUD_W{1'b0}};
        bit_d  = 3'd0;
        if (!q_empty_s) begin
          pop_s   = 1'b1;
          shift_d = q_dout_s;
          state_d = ST_START;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BAUD_W{1'b0}};
          if (!q_empty_s) begin
            pop_s   = 1'b1;
            shift_d = q_dout_s;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Reset tracks the toggle level so a level present at reset never becomes a write.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      tog_q   <= gpo_i[TOG_BIT];
      ovf_q   <= 1'b0;
      state_q <= ST_IDLE;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      tog_q   <= tog_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o    = tx_q;
  assign ovf_o   = ovf_q;
  assign ready_o = !q_full_s;
  assign busy_o  = (state_q != ST_IDLE) || (q_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_gpo_uart_tx.sv
// Directed self-checking bench for gpo_uart_tx (CLKDIV=4, FIFO_DEPTH=4).
// Expectations adapt to the queue depth selected by GPO_UART_TX_FIFO_EN.
`timescale 1ns/1ps
module tb_gpo_uart_tx;
  import gpo_uart_pkg::*;

  localparam int CLKDIV     = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef GPO_UART_TX_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLKDIV;
  localparam int NW        = QDEPTH + 2;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [7:0] gpo_i;
  logic       tx_o, ready_o, busy_o, ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] t3 [4] = '{8'hC8, 8'h49, 8'hCA, 8'h4B};
  logic [7:0] t4 [6] = '{8'hE1, 8'h62, 8'hE3, 8'h64, 8'hE5, 8'h66};
  logic [7:0] b5;

  always #5 clk = ~clk;

  gpo_uart_tx #(
    .CLKDIV     (CLKDIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_in  (rst_in),
    .gpo_i   (gpo_i),
    .tx_o    (tx_o),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level c cycles after the start bit began, for a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int idx;
    idx = c / CLKDIV;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  task automatic do_reset(input logic [7:0] g);
    rst_in = 1'b0;
    gpo_i  = g;
    tick();
    tick();
    chk("rst_tx",    32'(tx_o),    32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_ovf",   32'(ovf_o),   32'd0);
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0;
    gpo_i  = 8'h80;

    // Toggle level held through reset release must not start a frame.
    do_reset(8'h80);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_tx", 32'(tx_o), 32'd1);
    end
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Single 'A' frame.
    do_reset(8'h00);
    gpo_i = 8'hC1;
    tick();
    chk("a_e0_tx",    32'(tx_o),    32'd1);
    chk("a_e0_busy",  32'(busy_o),  32'd1);
    chk("a_e0_ready", 32'(ready_o), 32'(QDEPTH > 1));
    tick();
    chk("a_e1_ready", 32'(ready_o), 32'd1);
    for (int c = 0; c < FRAME_CYC; c++) begin
      chk("a_tx", 32'(tx_o), 32'(frame_bit(8'h41, c)));
      if (c == FRAME_CYC - 1) chk("a_last_busy", 32'(busy_o), 32'd1);
      tick();
    end
    chk("a_done_busy", 32'(busy_o), 32'd0);
    chk("a_done_tx",   32'(tx_o),   32'd1);

    // Four frames back to back with no idle gap.
    do_reset(8'h00);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int w;
          w = 0;
          while (!ready_o && w < 200) begin
            tick();
            w++;
          end
          chk("b2b_ready_wait", 32'(ready_o), 32'd1);
          gpo_i = t3[i];
          tick();
        end
      end
      begin
        tick();
        tick();
        for (int f = 0; f < 4; f++) begin
          for (int c = 0; c < FRAME_CYC; c++) begin
            chk("b2b_tx", 32'(tx_o), 32'(frame_bit({1'b0, t3[f][6:0]}, c)));
            tick();
          end
        end
        chk("b2b_busy", 32'(busy_o), 32'd0);
        chk("b2b_ovf",  32'(ovf_o),  32'd0);
      end
    join

    // Writes on consecutive cycles until one is dropped.
    for (int k = 0; k <= 1 + FRAME_CYC * (NW - 1); k++) begin
      int f;
      int c;
      logic exp_tx;
      logic exp_ready;
      if (k < NW) gpo_i = t4[k];
      tick();
      if (k == 0 || k > FRAME_CYC * (NW - 1)) begin
        exp_tx = 1'b1;
      end else begin
        f = (k - 1) / FRAME_CYC;
        c = (k - 1) % FRAME_CYC;
        exp_tx = frame_bit({1'b0, t4[f][6:0]}, c);
      end
      exp_ready = (k >= FRAME_CYC + 1) || (k < QDEPTH && !(k == 0 && QDEPTH == 1));
      chk("ovf_tx",    32'(tx_o),    32'(exp_tx));
      chk("ovf_ready", 32'(ready_o), 32'(exp_ready));
      chk("ovf_flag",  32'(ovf_o),   32'(k >= NW - 1));
    end
    chk("ovf_busy", 32'(busy_o), 32'd0);

    // Reset during DATA bit 3 abandons the frame and clears the overflow flag.
    chk("mid_pre_ovf", 32'(ovf_o), 32'd1);
    b5 = {~gpo_i[7], 7'h55};
    gpo_i = b5;
    tick();
    tick();
    chk("mid_start_tx", 32'(tx_o), 32'd0);
    repeat (17) tick();
    chk("mid_bit3_tx", 32'(tx_o), 32'(frame_bit(8'h55, 17)));
    chk("mid_bit3_busy", 32'(busy_o), 32'd1);
    rst_in = 1'b0;
    tick();
    chk("mid_rst_tx",    32'(tx_o),    32'd1);
    chk("mid_rst_busy",  32'(busy_o),  32'd0);
    chk("mid_rst_ovf",   32'(ovf_o),   32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    rst_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("mid_after_tx", 32'(tx_o), 32'd1);
    end
    chk("mid_after_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpo_uart_tx.md
# gpo_uart_tx

Toggle-strobed UART transmitter on the fsoc GPIO. The SoC writes `gpo_o[7:0]` as a command word: bit 7 is a toggle strobe and bits 6:0 carry a 7-bit ASCII character. The block queues each character and shifts it out as an 8N1 frame on a fabric pad. It drives `ready_o` back into the SoC's single `gpi_i` so firmware can poll for space.

## Interface
Parameters:
- `CLKDIV`, 87: clock cycles per bit; legal range ≥ 2 (87 gives 10 MHz / 115200).
- `FIFO_DEPTH`, 4: FIFO entries, power of two ≥ 2; only used with `GPO_UART_TX_FIFO_EN`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_in`  in  1  reset; synchronous, active-low.
- `gpo_i`  in  8  `gpo_o` of fsoc; bit 7 = toggle, bits 6:0 = data.
- `tx_o`  out  1  serial line, idle high.
- `ready_o`  out  1  1 = a write would be accepted; wired to fsoc `gpi_i`.
- `busy_o`  out  1  1 = frame in progress or data queued.
- `ovf_o`  out  1  sticky overflow flag.

## Operation
- Toggle detect: register `tog_q`. A write occurs when `gpo_i[7] != tog_q`; `tog_q` is then updated to `gpo_i[7]`.
- While `rst_in` = 0, `tog_q <= gpo_i[7]`, so a level present at reset never produces a frame.
- Accepted write: push `{1'b0, gpo_i[6:0]}` into the queue.
- Write while the queue is full: the byte is dropped and `ovf_o` is set to 1. The toggle is still consumed. `ovf_o` clears only on reset.
- A write and a pop in the same cycle with the queue full: the write is accepted and the count is unchanged.
- FSM states IDLE, START, DATA, STOP; baud counter `0..CLKDIV-1`; bit index `0..7`.
  - IDLE → START: queue non-empty. Pop into the shifter.
  - START → DATA: after CLKDIV cycles.
  - DATA: LSB first. After 8 bits of CLKDIV cycles each, go to STOP.
  - STOP → START: on the last STOP cycle with the queue non-empty, pop and go to START (no idle gap).
  - STOP → IDLE: on the last STOP cycle with the queue empty.
- `tx_o` is registered: 0 in START, data bit in DATA, 1 in STOP/IDLE.
- `busy_o` = (state != IDLE) | queue non-empty.
- `ready_o` = queue not full, derived from the registered count.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `ovf_o`=0. State IDLE, queue empty, counters 0.
- Write sampled at edge E0 → queue entry at E0 → pop at E1 → `tx_o` low after E1.
- Frame length is exactly 10·CLKDIV cycles. Back-to-back frames are contiguous.
- Reset asserted mid-frame:
  - at the next edge `tx_o`=1 and state is IDLE;
  - queue flushed and `ovf_o`=0;
  - the partial frame is abandoned.
- `ready_o` falls in the cycle after the write that fills the queue. It rises in the cycle after the pop that frees a slot.

## Configuration
- `GPO_UART_TX_FIFO_EN` defined: the queue is a FIFO_DEPTH-entry synchronous FIFO.
- Not defined: the queue is a single holding register (depth 1) in front of the shifter; `FIFO_DEPTH` is ignored. All other behaviour is identical.

## Structure
- Package `gpo_uart_pkg` holds:
  - FSM state enum typedef `uart_state_t`;
  - `FRAME_BITS` = 10;
  - `TOG_BIT` = 7 and `DATA_W` = 7.
- Sub-module `gpo_uart_fifo`: synchronous FIFO with push/pop/full/empty/count. It is instantiated only under `GPO_UART_TX_FIFO_EN`.

## Test plan
All tests use CLKDIV=4 and FIFO_DEPTH=4 unless stated.
- Reset → `tx_o`=1, `ready_o`=1, `busy_o`=0, `ovf_o`=0. `gpo_i`=0x80 held through reset release → no frame.
- From `gpo_i`=0x00, write 0xC1 ('A', toggle 0→1) → one cycle later `tx_o`=0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, stop high. `busy_o` falls 40 cycles after the start bit.
- Four writes on consecutive odd/even toggles (0xC8, 0x49, 0xCA, 0x4B) → four contiguous frames, 160 cycles, no idle cycle between stop and start bits.
- Six writes on six consecutive cycles → first byte goes to the shifter, next four fill the FIFO, sixth is dropped. `ovf_o`=1 from that cycle; `ready_o`=0 until the second frame starts.
- `rst_in` low for 1 cycle during DATA bit 3 → next edge `tx_o`=1, `busy_o`=0, `ovf_o`=0. No further frame unless a new toggle arrives.
- Build without `GPO_UART_TX_FIFO_EN` → three writes in three cycles: first is transmitted, second is held and sent contiguously, third is dropped with `ovf_o`=1.
